// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller around an inferred dual-port RAM with registered read data.
// Optional sticky overflow/underflow flags are enabled by defining RAM_FIFO_ERR_EN.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
`ifdef RAM_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CountFull = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] CountOne = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wr_en, rd_en;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  always_comb begin
    rd_en = read & ~empty_q;
    wr_en = write & (~full_q | rd_en);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrOne;

    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CountFull);
    empty_d = (count_d == '0);
  end

  // Storage is never reset; reset only blocks the write in its own cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      if (rd_en) begin
        data_q <= mem[rd_ptr_q];
      end
    end
  end

`ifdef RAM_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (write && !wr_en) overflow_q  <= 1'b1;
      if (read && empty_q) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign data_out = data_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

  // Occupancy invariants: count bounded, flags consistent with it.
  assert property (@(posedge clk) disable iff (reset) count_q <= CountFull);
  assert property (@(posedge clk) disable iff (reset) full_q == (count_q == CountFull));
  assert property (@(posedge clk) disable iff (reset) empty_q == (count_q == '0));

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: a queue model predicts acceptance, data, count and flags.
module tb_ram_fifo_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 12;
  localparam int unsigned Depth = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          write;
  logic [DW-1:0] data_in;
  logic          read;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef RAM_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  ram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .data_in  (data_in),
    .read     (read),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
`ifdef RAM_FIFO_ERR_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic rst = 1'b0);
    logic rd_ok, wr_ok;
    write   = w;
    data_in = d;
    read    = r;
    reset   = rst;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      rd_ok = r && (sb.size() > 0);
      wr_ok = w && ((sb.size() < Depth) || rd_ok);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && sb.size() == 0) m_udf = 1'b1;
      if (rd_ok) m_dout = sb.pop_front();
      if (wr_ok) sb.push_back(d);
    end
    #1;
    check_eq("count", 64'(count), 64'(sb.size()));
    check_eq("empty", 64'(empty), 64'(sb.size() == 0));
    check_eq("full", 64'(full), 64'(sb.size() == Depth));
    check_eq("data_out", data_out, m_dout);
`ifdef RAM_FIFO_ERR_EN
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("underflow", 64'(underflow), 64'(m_udf));
`endif
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; data_in = '0;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 64'hFFFF, 1'b1, 1'b1);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_dout", data_out, 64'd0);

    // Basic write then read
    step(1'b1, 64'hA5A5_0000_0000_0001, 1'b0);
    check_eq("s1_count1", 64'(count), 64'd1);
    step(1'b0, '0, 1'b1);
    check_eq("s1_dout", data_out, 64'hA5A5_0000_0000_0001);
    check_eq("s1_empty", 64'(empty), 64'd1);
    step(1'b0, '0, 1'b0);

    // Fill to full, then one extra write is rejected
    for (int i = 0; i < Depth; i++) step(1'b1, 64'(i), 1'b0);
    check_eq("fill_full", 64'(full), 64'd1);
    check_eq("fill_count", 64'(count), 64'd4096);
    step(1'b1, 64'hDEAD, 1'b0);
    check_eq("ovf_count", 64'(count), 64'd4096);

    // Write+read at full, then drain across the pointer wrap
    step(1'b1, 64'h1234, 1'b1);
    check_eq("full_rw_dout", data_out, 64'd0);
    check_eq("full_rw_count", 64'(count), 64'd4096);
    for (int i = 0; i < Depth; i++) step(1'b0, '0, 1'b1);
    check_eq("drain_last", data_out, 64'h1234);
    check_eq("drain_empty", 64'(empty), 64'd1);

    // Write+read when empty: read rejected
    step(1'b1, 64'h77, 1'b1);
    check_eq("empty_rw_count", 64'(count), 64'd1);
    check_eq("empty_rw_dout", data_out, 64'h1234);
    step(1'b0, '0, 1'b1);
    check_eq("empty_rw_next", data_out, 64'h77);

    // Read on empty, then idle
    step(1'b0, '0, 1'b1);
    check_eq("udf_dout", data_out, 64'h77);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);

    // Reset dominates a concurrent write
    for (int i = 0; i < 5; i++) step(1'b1, 64'(100 + i), 1'b0);
    step(1'b1, 64'hBEEF, 1'b0, 1'b1);
    check_eq("rstw_count", 64'(count), 64'd0);
    check_eq("rstw_empty", 64'(empty), 64'd1);
    step(1'b0, '0, 1'b1);
    check_eq("rstw_read_rej", data_out, 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL provide parameter: DATA_WIDTH, 64, width of each stored word.
REQ-002 SHALL provide parameter: ADDR_WIDTH, 12, memory address width; depth = 2**ADDR_WIDTH (4096).
REQ-003 SHALL provide port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port: write  input  1  write request.
REQ-006 SHALL provide port: data_in  input  DATA_WIDTH  write data.
REQ-007 SHALL provide port: read  input  1  read request.
REQ-008 SHALL provide port: data_out  output  DATA_WIDTH  registered read data.
REQ-009 SHALL provide port: full  output  1  high when count = depth.
REQ-010 SHALL provide port: empty  output  1  high when count = 0.
REQ-011 SHALL provide port: count  output  ADDR_WIDTH+1  number of stored words, 0..depth.
REQ-012 SHALL provide ports overflow and underflow, each output 1, sticky error flags, present only per REQ-031.

Function
REQ-013 SHALL contain an internal dual-port memory of depth x DATA_WIDTH, with one write port and one read port, both on clk.
REQ-014 SHALL accept a write iff write=1 and (full=0 or a read is accepted in the same cycle).
REQ-015 SHALL accept a read iff read=1 and empty=0.
REQ-016 An accepted write SHALL store data_in at wr_ptr and increment wr_ptr modulo depth, so that 4095 wraps to 0.
REQ-017 An accepted read SHALL load mem[rd_ptr] into data_out at the same edge and increment rd_ptr modulo depth; read latency is 1 cycle.
REQ-018 data_out SHALL hold its last value in any cycle with no accepted read.
REQ-019 count SHALL change by +1 on a write only, by -1 on a read only, and by 0 on both or neither.
REQ-020 full, empty and count SHALL be registered and SHALL reflect state after the most recent edge.
REQ-021 Simultaneous write and read when empty=1: the read SHALL be rejected, the write accepted, count SHALL become 1, and data_out SHALL be unchanged.
REQ-022 Simultaneous write and read when full=1: both SHALL be accepted, count SHALL stay at depth, and data_out SHALL receive the oldest word.
REQ-023 Simultaneous write and read at the same address (pointers equal, 0 < count < depth is impossible; covered by REQ-021/022): no write-through forwarding is required.
REQ-024 A rejected request SHALL have no effect on pointers, count, memory or data_out, except as specified in REQ-031.

Reset
REQ-025 When reset=1 at a clk edge, wr_ptr, rd_ptr and count SHALL become 0.
REQ-026 On reset, empty SHALL become 1, full 0, data_out 0, and overflow and underflow (if present) 0.
REQ-027 Reset SHALL dominate write and read asserted in the same cycle: no memory write or pointer update occurs.
REQ-028 Memory contents SHALL NOT be reset; a read after reset SHALL only return data written after reset.
REQ-029 The first request SHALL be accepted in the cycle after reset deasserts.

Configuration
REQ-030 Macro RAM_FIFO_ERR_EN SHALL control the presence of the error flags.
REQ-031 With RAM_FIFO_ERR_EN defined: overflow SHALL set on write=1 rejected by REQ-014, underflow SHALL set on read=1 with empty=1, and both SHALL stay set until reset.
REQ-032 Without RAM_FIFO_ERR_EN: the overflow and underflow ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Scenario: reset, write 0xA5A5_0000_0000_0001, then read next cycle -> data_out=0xA5A5_0000_0000_0001 one edge after the read, count 0->1->0, empty 1->0->1.
REQ-034 Scenario: 4096 consecutive writes of the index value -> full=1 and count=4096 after the 4096th; a 4097th write is rejected and count stays 4096 (overflow=1 if RAM_FIFO_ERR_EN).
REQ-035 Scenario: at full, write 0x1234 and read together -> data_out=0 (first word), count=4096; drain all -> last data_out=0x1234, confirming wr/rd pointer wrap to 0.
REQ-036 Scenario: when empty, write 0x77 and read together -> count=1 and data_out unchanged; read next cycle -> data_out=0x77.
REQ-037 Scenario: read with empty=1 -> no change to data_out or count (underflow=1 if RAM_FIFO_ERR_EN, still 1 after 10 idle cycles).
REQ-038 Scenario: after 5 writes, assert reset together with write=1 -> count=0, empty=1, and the next read is rejected.
